// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// default frame sync byte and frame length field width.
package prog_loader_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_START  = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Frame start marker
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Frame length field: 16-bit little-endian byte count
    localparam int LEN_W = 16;

endpackage

// File: rtl/prog_loader.sv
// Program loader: parses framed host byte stream (SYNC, LEN_LO, LEN_HI,
// payload, CSUM), writes payload into program RAM from address 0 and,
// if the checksum matches, starts the CPU with a one-cycle run pulse.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         AW   = 16,
    parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          cpu_idle,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_d,
    output logic          run,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0]    ADDR_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE  = 1;

    state_t            state_q;
    // Holds the received length, then counts down the payload bytes
    // still expected while in ST_DATA.
    logic [LEN_W-1:0]  len_q;
    logic [AW-1:0]     addr_q;
    logic [7:0]        sum_q;
    logic              ram_we_q;
    logic [AW-1:0]     ram_addr_q;
    logic [7:0]        ram_d_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic [LEN_W-1:0]  len_full;

    // Handshake and decoded status; the loader only stalls the host in START
    always_comb begin
        in_ready = (state_q != ST_START);
        accept   = in_valid && in_ready;
        len_full = {in_data, len_q[7:0]};
        busy     = (state_q != ST_IDLE) && (state_q != ST_ERR);
        // run is decoded so it is high only while still in START, in the
        // first cycle the CPU reports idle; the FSM leaves START at that edge.
        run      = (state_q == ST_START) && cpu_idle;
    end

    // Frame FSM with counters, checksum accumulator and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    // Only SYNC starts a frame; anything else is dropped
                    if (accept && (in_data == SYNC)) begin
                        state_q <= ST_LEN_LO;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        addr_q  <= '0;
                        sum_q   <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= in_data;
                        state_q    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= in_data;
                        state_q     <= (len_full != '0) ? ST_DATA : ST_CSUM;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        ram_d_q    <= in_data;
                        addr_q     <= addr_q + ADDR_ONE;
                        sum_q      <= sum_q + in_data;
                        len_q      <= len_q - LEN_ONE;
                        if (len_q == LEN_ONE) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (in_data == sum_q) begin
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (cpu_idle) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_d    = ram_d_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as
// payload bytes are driven and popped as write strobes appear.
module tb_prog_loader;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          cpu_idle;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_d;
    logic          run;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef logic [7:0] bq_t[$];

    wr_t exp_q[$];
    int  we_cyc[$];
    int  total = 0;
    int  bad   = 0;
    int  run_cnt = 0;
    int  cyc = 0;

    prog_loader #(.AW(AW), .SYNC(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cpu_idle (cpu_idle),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples outputs mid low phase, pops scoreboard on each write
    wr_t mon_e;
    always @(negedge clk) begin
        #2;
        if (ram_we === 1'b1) begin
            we_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", ram_addr, mon_e.addr);
                check("wr_data", ram_d, mon_e.data);
                $display("write addr=%0h data=%0h", ram_addr, ram_d);
            end
        end
        if (run === 1'b1) begin
            run_cnt++;
            check("run_with_we", ram_we, 32'd0);
            $display("run pulse at cycle %0d", cyc);
        end
    end

    // Drive one byte and hold it until accepted (bounded)
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input bq_t pl, input bit bad_cs, input int gap);
        logic [7:0] sum;
        logic [15:0] len;
        wr_t w;
        sum = 8'h00;
        len = 16'(pl.size());
        send_byte(8'hA5, gap);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        for (int i = 0; i < pl.size(); i++) begin
            w.addr = i;
            w.data = int'(pl[i]);
            exp_q.push_back(w);
            sum = sum + pl[i];
            send_byte(pl[i], gap);
        end
        send_byte(bad_cs ? sum + 8'h01 : sum, gap);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (busy && n < 200);
        if (busy) check(tag, 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t pl;
        bq_t empty_pl;
        int  rc;
        int  w0;
        wr_t w;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cpu_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", ram_we, 0);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame: three writes back-to-back, one run pulse
        rc = run_cnt;
        w0 = we_cyc.size();
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(pl, 1'b0, 0);
        wait_idle("f1_idle_timeout");
        check("f1_run_cnt", run_cnt - rc, 1);
        check("f1_done", done, 1);
        check("f1_err", err, 0);
        check("f1_pending", exp_q.size(), 0);
        check("f1_b2b_1", we_cyc[w0 + 1] - we_cyc[w0], 1);
        check("f1_b2b_2", we_cyc[w0 + 2] - we_cyc[w0 + 1], 1);
        $display("frame1 done=%0b err=%0b", done, err);

        // Bad checksum: writes happen, no run, error state
        rc = run_cnt;
        send_frame(pl, 1'b1, 0);
        repeat (3) @(negedge clk);
        #3;
        check("f2_run_cnt", run_cnt - rc, 0);
        check("f2_err", err, 1);
        check("f2_done", done, 0);
        check("f2_busy", busy, 0);
        check("f2_in_ready", in_ready, 1);
        check("f2_pending", exp_q.size(), 0);
        $display("frame2 done=%0b err=%0b", done, err);

        // Empty frame out of ERR
        rc = run_cnt;
        send_frame(empty_pl, 1'b0, 0);
        wait_idle("f3_idle_timeout");
        check("f3_run_cnt", run_cnt - rc, 1);
        check("f3_done", done, 1);
        check("f3_err", err, 0);
        $display("frame3 done=%0b err=%0b", done, err);

        // Junk before SYNC is dropped; SYNC inside payload/csum is data
        rc = run_cnt;
        w.addr = 0;
        w.data = 8'hA5;
        exp_q.push_back(w);
        pl = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5};
        foreach (pl[i]) send_byte(pl[i], 0);
        wait_idle("f4_idle_timeout");
        check("f4_run_cnt", run_cnt - rc, 1);
        check("f4_done", done, 1);
        check("f4_pending", exp_q.size(), 0);
        $display("frame4 done=%0b err=%0b", done, err);

        // CPU busy for 5 cycles after checksum: loader stalls in START
        rc = run_cnt;
        cpu_idle = 1'b0;
        pl = '{8'h05, 8'h06};
        send_frame(pl, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            check("f5_in_ready_low", in_ready, 0);
            check("f5_run_low", run, 0);
        end
        @(negedge clk);
        cpu_idle = 1'b1;
        #3;
        check("f5_run_high", run, 1);
        @(posedge clk);
        #1;
        check("f5_run_cnt", run_cnt - rc, 1);
        check("f5_done", done, 1);
        check("f5_busy", busy, 0);
        $display("frame5 done=%0b err=%0b", done, err);

        // Reset after the second payload byte of a 4-byte frame
        rc = run_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        w.addr = 0; w.data = 8'h10; exp_q.push_back(w);
        send_byte(8'h10, 0);
        w.addr = 1; w.data = 8'h20; exp_q.push_back(w);
        send_byte(8'h20, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("f6_ram_we", ram_we, 0);
        check("f6_run", run, 0);
        check("f6_busy", busy, 0);
        check("f6_done", done, 0);
        check("f6_err", err, 0);
        check("f6_in_ready", in_ready, 1);
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        repeat (4) @(negedge clk);
        #3;
        check("f6_run_cnt", run_cnt - rc, 0);
        check("f6_pending", exp_q.size(), 0);
        check("f6_busy_after", busy, 0);
        $display("frame6 reset abort busy=%0b", busy);

        // 256-byte frame with random valid gaps
        rc = run_cnt;
        w0 = we_cyc.size();
        pl = {};
        for (int i = 0; i < 256; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(pl, 1'b0, 2);
        wait_idle("f7_idle_timeout");
        check("f7_we_cnt", we_cyc.size() - w0, 256);
        check("f7_run_cnt", run_cnt - rc, 1);
        check("f7_pending", exp_q.size(), 0);
        check("f7_done", done, 1);
        check("f7_err", err, 0);
        $display("frame7 done=%0b err=%0b", done, err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter AW, default 16: RAM byte-address width, matches abus.
REQ-002 Parameter SYNC, default 8'hA5: frame start byte.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  host byte stream valid.
REQ-006 in_data  input  8  host byte.
REQ-007 in_ready  output  1  loader can accept byte; transfer occurs when in_valid && in_ready at a clock edge.
REQ-008 cpu_idle  input  1  high while the CPU state machine is in IDLE.
REQ-009 ram_we  output  1  one-cycle byte write strobe to program RAM.
REQ-010 ram_addr  output  AW  write byte address.
REQ-011 ram_d  output  8  write byte.
REQ-012 run  output  1  one-cycle start pulse to CPU.
REQ-013 busy  output  1  frame in progress (any state but IDLE, ERR).
REQ-014 done  output  1  last frame loaded and CPU started.
REQ-015 err  output  1  last frame failed checksum.

Function
REQ-016 Frame format SHALL be: SYNC, LEN_LO, LEN_HI, LEN payload bytes, CSUM; LEN is 16-bit little-endian byte count; CSUM is the 8-bit modulo-256 sum of the payload.
REQ-017 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, CSUM, START, ERR.
REQ-018 in_ready SHALL be 1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR and 0 in START.
REQ-019 IDLE/ERR: accepted byte == SYNC -> LEN_LO, clears done and err; any other byte is discarded, state unchanged.
REQ-020 LEN_LO: accepted byte -> len[7:0], go LEN_HI; LEN_HI: accepted byte -> len[15:8], go DATA if len != 0, else CSUM.
REQ-021 DATA: each accepted byte SHALL be written to RAM at address 0,1,2,... in order; running sum updated; after the len-th byte go CSUM.
REQ-022 Write latency SHALL be exactly one cycle: byte accepted at edge N -> ram_we=1 with ram_addr/ram_d valid during cycle N+1; ram_we=0 otherwise.
REQ-023 Back-to-back bytes SHALL produce back-to-back write strobes; in_valid low stalls without a write.
REQ-024 Address counter SHALL be AW bits, reset to 0 on each SYNC; len up to 2^AW-1 never wraps.
REQ-025 CSUM: accepted byte == sum -> START; else -> ERR with err=1.
REQ-026 START: while cpu_idle=0 wait; first cycle with cpu_idle=1 assert run for exactly one cycle, set done=1, go IDLE.
REQ-027 run SHALL never be asserted while ram_we is high, nor in any state other than START.
REQ-028 err and done SHALL be mutually exclusive and hold until the next SYNC or reset.
REQ-029 In LEN_LO, LEN_HI, DATA, CSUM the value SYNC is ordinary data, not a restart.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, address and sum to 0, len to 0, and ram_we, run, busy, done, err to 0; in_ready=1 after reset.
REQ-031 Reset mid-frame SHALL abort the frame with no further write or run pulse; RAM contents already written are left as is.

Structure
REQ-032 State encodings, SYNC default, and frame field names SHALL live in a shared include alongside the existing state/opcode definition files.
REQ-033 Block SHALL be one module, no sub-modules; FSM, len/addr counters, checksum accumulator, and registered write port held in it.

Verification
REQ-034 Frame A5 03 00 11 22 33 66, cpu_idle=1 -> writes (0,11),(1,22),(2,33) on consecutive cycles, one run pulse, done=1, err=0.
REQ-035 Same frame with CSUM 67 -> three writes, no run, err=1, busy=0; then A5 00 00 00 -> run pulse, done=1, err=0.
REQ-036 Bytes 00 FF A5 01 00 A5 A5 -> first two discarded, one write (0,A5), run pulse.
REQ-037 Valid frame with cpu_idle=0 for 5 cycles after CSUM -> in_ready=0, no run; run pulses in the first cycle cpu_idle=1.
REQ-038 rst asserted after second payload byte of a 4-byte frame -> no further ram_we, no run, all outputs at reset values next cycle.
REQ-039 in_valid toggled randomly over a 256-byte frame -> exactly 256 writes, addresses 0..255 in order, correct data, one run pulse.
